// File: rtl/mem_req_ctrl_pkg.sv
// Shared types and default geometry for the register-file request controller.
// State encoding is fixed so waveforms and debug taps read the same across builds.
package mem_ctrl_pkg;

  localparam int DEF_W  = 7;
  localparam int DEF_L  = 10;
  localparam int DEF_AW = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/mem_req_ctrl.sv
// Single-outstanding req/resp front end for the register-file memory; latency write 2, read 3, error 1.
// Request side stalls (req_ready=0) until the response handshake; response is held under resp_ready=0.
module mem_req_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int L  = DEF_L,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [W:0]    req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [W:0]    resp_rdata,
  output logic          resp_err,
  output logic [W:0]    mem_write,
  output logic [AW-1:0] mem_add,
  output logic          mem_enable,
  input  logic [W:0]    mem_out
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(L);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_we;
  logic          r_err;
  logic [W:0]    r_rdata;
  logic [W:0]    r_mem_write;
  logic [AW-1:0] r_mem_add;
  logic          r_mem_enable;

  logic          w_we_nxt;
  logic          w_err_nxt;
  logic [W:0]    w_rdata_nxt;
  logic [W:0]    w_mem_write_nxt;
  logic [AW-1:0] w_mem_add_nxt;
  logic          w_mem_enable_nxt;
  logic          w_req_err;

  // The memory only commits nonzero data, so a zero write would silently do nothing.
  assign w_req_err = (req_addr > LAST_ADDR) || (req_we && (req_wdata == '0));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_we_nxt         = r_we;
    w_err_nxt        = r_err;
    w_rdata_nxt      = r_rdata;
    w_mem_write_nxt  = '0;
    w_mem_add_nxt    = r_mem_add;
    w_mem_enable_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_we_nxt = req_we;
          if (w_req_err) begin
            w_state_nxt = S_RESP;
            w_err_nxt   = 1'b1;
            w_rdata_nxt = '0;
          end else begin
            w_state_nxt      = S_ISSUE;
            w_mem_add_nxt    = req_addr;
            w_mem_enable_nxt = req_we;
            w_mem_write_nxt  = req_we ? req_wdata : '0;
          end
        end
      end
      S_ISSUE: begin
        if (r_we) begin
          w_state_nxt = S_RESP;
          w_rdata_nxt = '0;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // Registered read: data for the ISSUE address is on mem_out now.
        w_state_nxt = S_RESP;
        w_rdata_nxt = mem_out;
      end
      S_RESP: begin
        if (resp_ready) begin
          w_state_nxt = S_IDLE;
          w_err_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we         <= 1'b0;
      r_err        <= 1'b0;
      r_rdata      <= '0;
      r_mem_write  <= '0;
      r_mem_add    <= '0;
      r_mem_enable <= 1'b0;
    end else begin
      r_we         <= w_we_nxt;
      r_err        <= w_err_nxt;
      r_rdata      <= w_rdata_nxt;
      r_mem_write  <= w_mem_write_nxt;
      r_mem_add    <= w_mem_add_nxt;
      r_mem_enable <= w_mem_enable_nxt;
    end
  end

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;
  assign mem_write  = r_mem_write;
  assign mem_add    = r_mem_add;
  assign mem_enable = r_mem_enable;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Bench for mem_req_ctrl driving a behavioural model of the register-file memory.
module tb_mem_req_ctrl;

  localparam int W  = 7;
  localparam int L  = 10;
  localparam int AW = 4;

  typedef struct {
    logic       err;
    logic [7:0] rdata;
    int         lat;
  } exp_t;

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic       err;
    logic [7:0] rdata;
    int         lat;
    int         en;
  } vec_t;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [W:0]    req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [W:0]    resp_rdata;
  logic          resp_err;
  logic [W:0]    mem_write;
  logic [AW-1:0] mem_add;
  logic          mem_enable;
  logic [W:0]    mem_out;
  logic          mem_rst;

  exp_t exp_q[$];
  int   acc_q[$];
  int   acc_log[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   rise_cyc = 0;
  int   en_cnt = 0;
  logic prev_vld = 1'b0;

  mem_req_ctrl #(.W(W), .L(L), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_write  (mem_write),
    .mem_add    (mem_add),
    .mem_enable (mem_enable),
    .mem_out    (mem_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: writes only nonzero data when enabled, registered read every cycle.
  logic [7:0] mem_arr [0:15];
  assign mem_rst = ~reset;
  always @(posedge clk or posedge mem_rst) begin
    if (mem_rst) begin
      for (int k = 0; k < 16; k++) mem_arr[k] <= 8'h00;
      mem_out <= 8'h00;
    end else begin
      if (mem_enable && (mem_write != 8'h00)) mem_arr[mem_add] <= mem_write;
      mem_out <= mem_arr[mem_add];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Monitor: accept log, valid-rise time, enable count and scoreboard pop on handshake.
  always @(negedge clk) begin
    exp_t e;
    int   a;
    cyc++;
    if (req_valid && req_ready) begin
      acc_q.push_back(cyc);
      acc_log.push_back(cyc);
    end
    if (resp_valid && !prev_vld) rise_cyc = cyc;
    prev_vld = resp_valid;
    if (mem_enable) en_cnt++;
    if (resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        check("resp_unexpected", 32'(resp_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        if (acc_q.size() > 0) a = acc_q.pop_front();
        else a = -1000;
        check("resp_err", 32'(resp_err), 32'(e.err));
        check("resp_rdata", 32'(resp_rdata), 32'(e.rdata));
        check("latency", 32'(rise_cyc - a), 32'(e.lat));
      end
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (req_ready) break;
    end
    check("req_ready_wait", 32'(req_ready), 32'd1);
  endtask

  task automatic send(input logic we, input logic [3:0] addr, input logic [7:0] wd,
                      input logic e_err, input logic [7:0] e_rd, input int e_lat);
    exp_t e;
    wait_ready();
    e.err   = e_err;
    e.rdata = e_rd;
    e.lat   = e_lat;
    exp_q.push_back(e);
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    check("resp_pending", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, want finish before 400us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vt [10];
    exp_t e;
    int   en0;
    int   base;
    logic [3:0] add0;

    vt[0] = '{1'b1, 4'd3,  8'h5A, 1'b0, 8'h00, 2, 1};
    vt[1] = '{1'b0, 4'd3,  8'h00, 1'b0, 8'h5A, 3, 0};
    vt[2] = '{1'b1, 4'd2,  8'h33, 1'b0, 8'h00, 2, 1};
    vt[3] = '{1'b1, 4'd2,  8'h00, 1'b1, 8'h00, 1, 0};
    vt[4] = '{1'b0, 4'd2,  8'hC3, 1'b0, 8'h33, 3, 0};
    vt[5] = '{1'b0, 4'd11, 8'h00, 1'b1, 8'h00, 1, 0};
    vt[6] = '{1'b1, 4'd15, 8'h01, 1'b1, 8'h00, 1, 0};
    vt[7] = '{1'b1, 4'd0,  8'h11, 1'b0, 8'h00, 2, 1};
    vt[8] = '{1'b1, 4'd10, 8'hFF, 1'b0, 8'h00, 2, 1};
    vt[9] = '{1'b0, 4'd5,  8'h00, 1'b0, 8'h00, 3, 0};

    reset      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_resp_rdata", 32'(resp_rdata), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_mem_add", 32'(mem_add), 32'd0);
    check("rst_mem_enable", 32'(mem_enable), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 10; i++) begin
      en0  = en_cnt;
      add0 = mem_add;
      send(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].err, vt[i].rdata, vt[i].lat);
      wait_done();
      check("enable_cycles", 32'(en_cnt - en0), 32'(vt[i].en));
      if (vt[i].err) check("err_add_hold", 32'(mem_add), 32'(add0));
    end

    // Back-to-back reads with req_valid held high: accepts must land 4 cycles apart.
    wait_ready();
    base = acc_log.size();
    e = '{1'b0, 8'h11, 3};
    exp_q.push_back(e);
    e = '{1'b0, 8'hFF, 3};
    exp_q.push_back(e);
    req_we    = 1'b0;
    req_addr  = 4'd0;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_addr = 4'd10;
    for (int i = 0; i < 20 && acc_log.size() < base + 2; i++) begin
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    wait_done();
    check("b2b_accepts", 32'(acc_log.size() - base), 32'd2);
    if (acc_log.size() >= base + 2) check("b2b_spacing", 32'(acc_log[base+1] - acc_log[base]), 32'd4);

    // Backpressure: response must sit still while resp_ready is low.
    wait_ready();
    resp_ready = 1'b0;
    send(1'b0, 4'd3, 8'h00, 1'b0, 8'h5A, 3);
    for (int i = 0; i < 10 && !resp_valid; i++) @(negedge clk);
    check("bp_valid_rise", 32'(resp_valid), 32'd1);
    repeat (5) begin
      @(negedge clk);
      check("bp_valid_hold", 32'(resp_valid), 32'd1);
      check("bp_rdata_hold", 32'(resp_rdata), 32'h5A);
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    wait_done();
    @(posedge clk);
    #1;
    check("bp_done_valid", 32'(resp_valid), 32'd0);
    check("bp_done_ready", 32'(req_ready), 32'd1);
    check("bp_rdata_after", 32'(resp_rdata), 32'h5A);

    // Reset during WAIT of a read: abort with no response, memory cleared.
    wait_ready();
    req_we    = 1'b0;
    req_addr  = 4'd3;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    acc_q.delete();
    check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    check("mid_rst_resp_err", 32'(resp_err), 32'd0);
    check("mid_rst_rdata", 32'(resp_rdata), 32'd0);
    check("mid_rst_mem_enable", 32'(mem_enable), 32'd0);
    check("mid_rst_mem_add", 32'(mem_add), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_req_ready", 32'(req_ready), 32'd1);
    repeat (6) @(negedge clk);
    check("mid_rst_no_resp", 32'(resp_valid), 32'd0);
    send(1'b0, 4'd3, 8'h00, 1'b0, 8'h00, 3);
    wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_req_ctrl.md
Name: mem_req_ctrl

Overview:
- Initiator-side controller for the team's single-port register-file memory (8-bit data, 4-bit address, write-when-nonzero-and-enabled, registered read).
- Accepts one read or write request at a time over a valid/ready request channel and drives the memory's write/add/enable pins.
- Returns read data or write completion over a valid/ready response channel.
- Enforces the memory's corner rules so upstream blocks never touch the memory pins directly.

Parameters:
- W, 7, MSB index of data; data width is W+1.
- L, 10, highest valid memory address; depth is L+1.
- AW, 4, address width; must satisfy 2**AW > L.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  AW  target address.
- req_wdata  input  W+1  write data.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts the response.
- resp_rdata  output  W+1  read data; 0 for writes and errors.
- resp_err  output  1  request rejected, no memory access made.
- mem_write  output  W+1  to memory write-data pin.
- mem_add  output  AW  to memory address pin.
- mem_enable  output  1  to memory enable pin.
- mem_out  input  W+1  from memory registered read output.

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to IDLE.
  - req_ready=1 once reset releases.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_write=0, mem_add=0, mem_enable=0.
  - All memory-pin outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - A request is accepted on a clock edge where req_valid=1; req_we, req_addr and req_wdata are latched.
  - Error check at accept. The request is an error if either:
    - req_addr > L, or
    - req_we=1 and req_wdata==0. The memory cannot store zero, because its write condition is data nonzero AND enable.
  - On error: go to RESP with resp_err=1, resp_rdata=0. Memory pins stay idle.
  - Otherwise go to ISSUE.
- ISSUE, one cycle:
  - mem_add = latched address.
  - For a write: mem_write = wdata, mem_enable=1, then go to RESP.
  - For a read: mem_write=0, mem_enable=0, then go to WAIT.
- WAIT, one cycle:
  - Pins return to idle values.
  - mem_out is valid this cycle.
  - resp_rdata captures mem_out at the closing edge; go to RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable.
  - On resp_ready=1, go to IDLE at that edge, with resp_valid=0 and resp_err=0 next cycle.
  - resp_rdata holds its last value until the next response.
- Idle pin values: mem_enable=0, mem_write=0, mem_add holds the last address. The memory performs harmless reads while idle.
- req_ready is 0 in ISSUE, WAIT and RESP. There is no pipelining; at most one transaction is outstanding.
- Latency from the accept edge to resp_valid rising:
  - write: 2 cycles.
  - read: 3 cycles.
  - error: 1 cycle.
- Back-to-back: a new request can be accepted the cycle after the RESP handshake. Minimum read throughput is one per 4 cycles when resp_ready is held at 1.
- Request fields are ignored when not in IDLE. req_valid may drop without effect.
- Reset asserted mid-transaction aborts immediately; all outputs go to reset values.
  - A write whose ISSUE edge coincided with reset assertion is not guaranteed.
  - The bench must not depend on it.

Decomposition:
- Package mem_ctrl_pkg:
  - state enum/localparams S_IDLE=0, S_ISSUE=1, S_WAIT=2, S_RESP=3;
  - default W, L, AW.
- No sub-module; a single FSM with a datapath register.
- The testbench instantiates mem_req_ctrl driving the existing memory model, with an active-high memory reset derived as the inverse of reset.

Test Plan:
- Write then read: write addr 3 data 0x5A; read addr 3. Write response arrives 2 cycles after accept with err=0; read response arrives 3 cycles after accept with rdata=0x5A.
- Zero-write rejection: write addr 2 data 0x00 -> resp_err=1 after 1 cycle, mem_enable never asserted, a subsequent read of addr 2 returns its prior value.
- Out-of-range: read addr 11 and write addr 15 data 0x01 -> both resp_err=1, rdata=0, no memory-pin activity.
- Backpressure: read addr 3 with resp_ready held 0 for 5 cycles -> resp_valid and rdata=0x5A stable throughout, req_ready=0; completes on the cycle resp_ready=1.
- Boundary and back-to-back: write addr 0 = 0x11 and addr 10 = 0xFF, then read both with resp_ready=1 -> 0x11 and 0xFF, reads spaced exactly 4 cycles apart.
- Reset mid-read: pull reset low during WAIT -> resp_valid=0, req_ready=1 after release, no spurious response; a later read of addr 3 after reset returns 0.
